// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared constants and types for the nested interrupt
//               controller: default source count and vector layout, the
//               request FSM state type and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    localparam int          N_SRC_DEF      = 3;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_1000;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0080;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } intr_state_e;

    // Width of an index into an n-bit vector; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : intr_prio_enc
// Description : N-bit priority encoder. Reports the index of the highest set
//               bit of i_vec and whether any bit is set at all.
// Ports       : vec_in  [N-1:0]     request vector (bit N-1 is highest)
//               idx_out [IDX_W-1:0] index of highest set bit (0 when none)
//               vld_out             at least one bit of vec_in is set
// Revision    : 1.0 - initial release
// ============================================================================
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int N     = N_SRC_DEF,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     vec_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             vld_out
);

    always_comb begin
        idx_out = '0;
        // Ascending scan: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < N; i++) begin
            if (vec_in[i]) begin
                idx_out = IDX_W'(i);
            end
        end
        vld_out = |vec_in;
    end

endmodule
`default_nettype wire

// File: rtl/intr_priority_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_priority_ctrl
// Description : Nested interrupt controller. Captures rising edges on the
//               interrupt lines into a pending register, compares the highest
//               enabled pending source with the level in service, and raises
//               a request plus handler vector when the source is higher.
//               Nesting is unwound one level per ERET.
// Options     : INTR_SYNC_EN - when defined, irq_in passes through a 2-flop
//               synchronizer ahead of edge detection (+2 cycles latency).
// Ports       : clk, clr_n (async active-low reset)
//               irq_in        raw interrupt lines
//               int_en_we/_wdata  enable-mask write port
//               cpu_int_req/_vec  request and handler address to the CPU
//               cpu_int_ack   CPU accepted the request
//               cpu_eret      handler returned
//               in_service    running flag per level
//               pending       captured, not yet serviced sources
//               err_eret      pulse on ERET with nothing in service
// Revision    : 1.0 - initial release
// ============================================================================
module intr_priority_ctrl
    import intr_pkg::*;
#(
    parameter int          N_SRC      = N_SRC_DEF,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             int_en_we,
    input  logic [N_SRC-1:0] int_en_wdata,
    output logic             cpu_int_req,
    output logic [31:0]      cpu_int_vec,
    input  logic             cpu_int_ack,
    input  logic             cpu_eret,
    output logic [N_SRC-1:0] in_service,
    output logic [N_SRC-1:0] pending,
    output logic             err_eret
);

    localparam int IDX_W = idx_w(N_SRC);

    intr_state_e      state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             req_q, req_d;
    logic [31:0]      vec_q, vec_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] svc_q, svc_d;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] irq_q, irq_d;
    logic             err_q, err_d;

    logic [N_SRC-1:0] w_irq_s;
    logic [N_SRC-1:0] w_edge;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_cand_vld;
    logic [IDX_W-1:0] w_svc_idx;
    logic             w_svc_vld;
    logic             w_eligible;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef INTR_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign w_irq_s = sync2_q;
`else
    assign w_irq_s = irq_in;
`endif

    // A line held high produces a single edge.
    assign w_edge = w_irq_s & ~irq_q;

    // ------------------------------------------------------------------
    // Priority resolution
    // ------------------------------------------------------------------
    intr_prio_enc #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_cand_enc (
        .vec_in  (pend_q & en_q),
        .idx_out (w_cand_idx),
        .vld_out (w_cand_vld)
    );

    intr_prio_enc #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_lvl_enc (
        .vec_in  (svc_q),
        .idx_out (w_svc_idx),
        .vld_out (w_svc_vld)
    );

    // cur_lvl = svc_idx+1 (0 when idle), so cand+1 > cur_lvl reduces to this.
    assign w_eligible = w_cand_vld && (!w_svc_vld || (w_cand_idx > w_svc_idx));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        vec_d   = vec_q;
        pend_d  = pend_q;
        svc_d   = svc_q;
        err_d   = 1'b0;
        irq_d   = w_irq_s;
        en_d    = int_en_we ? int_en_wdata : en_q;

        // ERET first so that a same-cycle ack lands on the reduced stack.
        if (cpu_eret) begin
            if (w_svc_vld) begin
                svc_d[w_svc_idx] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (w_eligible) begin
                    sel_d   = w_cand_idx;
                    vec_d   = VEC_BASE + VEC_STRIDE * 32'(w_cand_idx);
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cpu_int_ack) begin
                    svc_d[sel_q]  = 1'b1;
                    pend_d[sel_q] = 1'b0;
                    req_d         = 1'b0;
                    state_d       = GAP;
                end else if (!en_q[sel_q]) begin
                    // Source masked before the CPU took it: withdraw, keep pending.
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // New edges override the acknowledge clear.
        pend_d = pend_d | w_edge;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            req_q   <= 1'b0;
            vec_q   <= VEC_BASE;
            pend_q  <= '0;
            svc_q   <= '0;
            en_q    <= '0;
            irq_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            svc_q   <= svc_d;
            en_q    <= en_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    assign cpu_int_req = req_q;
    assign cpu_int_vec = vec_q;
    assign in_service  = svc_q;
    assign pending     = pend_q;
    assign err_eret    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_priority_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_priority_ctrl
// Description : Directed, table-driven self-checking bench for
//               intr_priority_ctrl (N_SRC=3), plus hand-written sequences
//               for asynchronous reset, stray ERET and request latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_priority_ctrl;

    typedef struct {
        logic [2:0]  irq;
        logic        we;
        logic [2:0]  wd;
        logic        ack;
        logic        eret;
        logic        req;
        logic [31:0] vec;
        logic [2:0]  svc;
        logic [2:0]  pend;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [2:0]  irq_in;
    logic        int_en_we;
    logic [2:0]  int_en_wdata;
    logic        cpu_int_req;
    logic [31:0] cpu_int_vec;
    logic        cpu_int_ack;
    logic        cpu_eret;
    logic [2:0]  in_service;
    logic [2:0]  pending;
    logic        err_eret;

    int checks   = 0;
    int failures = 0;
    vec_t tv[$];

    intr_priority_ctrl #(
        .N_SRC      (3),
        .VEC_BASE   (32'h0000_1000),
        .VEC_STRIDE (32'h0000_0080)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .irq_in       (irq_in),
        .int_en_we    (int_en_we),
        .int_en_wdata (int_en_wdata),
        .cpu_int_req  (cpu_int_req),
        .cpu_int_vec  (cpu_int_vec),
        .cpu_int_ack  (cpu_int_ack),
        .cpu_eret     (cpu_eret),
        .in_service   (in_service),
        .pending      (pending),
        .err_eret     (err_eret)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] irq, input logic we, input logic [2:0] wd,
                                input logic ack, input logic eret, input logic req,
                                input logic [31:0] vec, input logic [2:0] svc,
                                input logic [2:0] pend, input logic err);
        vec_t v;
        v.irq = irq; v.we = we; v.wd = wd; v.ack = ack; v.eret = eret;
        v.req = req; v.vec = vec; v.svc = svc; v.pend = pend; v.err = err;
        return v;
    endfunction

    // Compare all observable outputs against expectations; vector only while requesting.
    task automatic check_out(input string name, input logic req, input logic [31:0] vec,
                             input logic [2:0] svc, input logic [2:0] pend, input logic err);
        logic ok;
        ok = (cpu_int_req === req) && (in_service === svc) && (pending === pend) &&
             (err_eret === err) && (!req || (cpu_int_vec === vec));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got req=%b vec=%h svc=%b pend=%b err=%b, want req=%b vec=%h svc=%b pend=%b err=%b",
                     name, cpu_int_req, cpu_int_vec, in_service, pending, err_eret,
                     req, vec, svc, pend, err);
        end
    endtask

    task automatic drive_idle();
        irq_in = 3'b000; int_en_we = 1'b0; int_en_wdata = 3'b000;
        cpu_int_ack = 1'b0; cpu_eret = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 1'b0, 32'h1000, 3'b000, 3'b000, 1'b0);
        if (cpu_int_vec !== 32'h1000) begin
            failures++;
            $display("FAIL reset_vec: got %h want %h", cpu_int_vec, 32'h1000);
        end
        checks++;
        clr_n = 1'b1;
    endtask

    task automatic measure_latency(input int want);
        int cnt;
        cnt = 0;
        int_en_we = 1'b1; int_en_wdata = 3'b111;
        @(posedge clk); #1;
        int_en_we = 1'b0;
        irq_in = 3'b001;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            irq_in = 3'b000;
            if (cpu_int_req === 1'b1) begin
                cnt = i;
                break;
            end
        end
        checks++;
        if (cnt != want) begin
            failures++;
            $display("FAIL latency: got %0d posedges (0 = timeout) want %0d", cnt, want);
        end
        check_out("latency_vec", 1'b1, 32'h1000, 3'b000, 3'b001, 1'b0);
    endtask

    initial begin
        // irq we wd ack eret | req vec svc pend err
        // Single source 0
        tv.push_back(mk(3'b000,1,3'b111,0,0, 0,32'h1000,3'b000,3'b000,0));
        tv.push_back(mk(3'b001,0,3'b000,0,0, 0,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1000,3'b001,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1000,3'b001,3'b000,0));
        // Nest source 2 over 0, unwind
        tv.push_back(mk(3'b100,0,3'b000,0,0, 0,32'h1100,3'b001,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1100,3'b001,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1100,3'b101,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1100,3'b001,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1100,3'b000,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1100,3'b000,3'b000,1));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1100,3'b000,3'b000,0));
        // Lower source waits under source 2
        tv.push_back(mk(3'b100,0,3'b000,0,0, 0,32'h1100,3'b000,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1100,3'b000,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1100,3'b100,3'b000,0));
        tv.push_back(mk(3'b001,0,3'b000,0,0, 0,32'h1100,3'b100,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1100,3'b100,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1100,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1000,3'b001,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1000,3'b000,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1000,3'b000,3'b000,0));
        // Simultaneous sources 0 and 1
        tv.push_back(mk(3'b011,0,3'b000,0,0, 0,32'h1000,3'b000,3'b011,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1080,3'b000,3'b011,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1080,3'b010,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1080,3'b010,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1080,3'b010,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1080,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1000,3'b001,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1000,3'b000,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1000,3'b000,3'b000,0));
        // Masked source still captures; enabling releases it a cycle later
        tv.push_back(mk(3'b000,1,3'b110,0,0, 0,32'h1000,3'b000,3'b000,0));
        tv.push_back(mk(3'b001,0,3'b000,0,0, 0,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,1,3'b111,0,0, 0,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1000,3'b000,3'b001,0));
        // Mask cleared during REQ withdraws the request
        tv.push_back(mk(3'b000,1,3'b110,0,0, 1,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,1,3'b111,0,0, 0,32'h1000,3'b000,3'b001,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1000,3'b000,3'b001,0));
        // Higher source during REQ: vector frozen, preempts after ack
        tv.push_back(mk(3'b100,0,3'b000,0,0, 1,32'h1000,3'b000,3'b101,0));
        tv.push_back(mk(3'b000,0,3'b000,1,0, 0,32'h1000,3'b001,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1000,3'b001,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1100,3'b001,3'b100,0));
        // ERET and ack together: ERET pops level 1, ack pushes level 3
        tv.push_back(mk(3'b000,0,3'b000,1,1, 0,32'h1100,3'b100,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 0,32'h1100,3'b100,3'b000,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1100,3'b000,3'b000,0));
        // Edge in the ack cycle re-pends the same source
        tv.push_back(mk(3'b100,0,3'b000,0,0, 0,32'h1100,3'b000,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1100,3'b000,3'b100,0));
        tv.push_back(mk(3'b100,0,3'b000,1,0, 0,32'h1100,3'b100,3'b100,0));
        tv.push_back(mk(3'b100,0,3'b000,0,0, 0,32'h1100,3'b100,3'b100,0));
        tv.push_back(mk(3'b100,0,3'b000,0,0, 0,32'h1100,3'b100,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,1, 0,32'h1100,3'b000,3'b100,0));
        tv.push_back(mk(3'b000,0,3'b000,0,0, 1,32'h1100,3'b000,3'b100,0));

        do_reset();

`ifndef INTR_SYNC_EN
        for (int i = 0; i < tv.size(); i++) begin
            irq_in       = tv[i].irq;
            int_en_we    = tv[i].we;
            int_en_wdata = tv[i].wd;
            cpu_int_ack  = tv[i].ack;
            cpu_eret     = tv[i].eret;
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), tv[i].req, tv[i].vec, tv[i].svc,
                      tv[i].pend, tv[i].err);
        end
        drive_idle();

        // Asynchronous reset while a request is outstanding
        #2;
        clr_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 32'h1000, 3'b000, 3'b000, 1'b0);
        checks++;
        if (cpu_int_vec !== 32'h1000) begin
            failures++;
            $display("FAIL async_reset_vec: got %h want %h", cpu_int_vec, 32'h1000);
        end
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Stray ERET: one-cycle error pulse
        cpu_eret = 1'b1;
        @(posedge clk); #1;
        cpu_eret = 1'b0;
        check_out("stray_eret", 1'b0, 32'h1000, 3'b000, 3'b000, 1'b1);
        @(posedge clk); #1;
        check_out("stray_eret_end", 1'b0, 32'h1000, 3'b000, 3'b000, 1'b0);

        measure_latency(2);
`else
        measure_latency(4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
